// File: rtl/rpi_bus_rx.sv
// Receiver for the Raspberry Pi GPIO parallel bus: synchronises strobe and data,
// emits one byte write per strobe rise, frames bytes and aborts stalled frames.
module rpi_bus_rx #(
  parameter int FRAME_BYTES = 2,
  parameter int IDX_W       = 1,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             clk_100mhz,
  input  logic             rst_n,
  input  logic [0:7]       RPI_IO,
  input  logic             rpi_strobe,
  output logic             rpi_ack,
  output logic [0:7]       data_out,
  output logic             data_valid,
  output logic [IDX_W-1:0] byte_idx,
  output logic             frame_done,
  output logic             frame_err,
  output logic             busy,
  output logic             LED1,
  output logic             LED2
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BYTES - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state, state_nxt;
  logic             s1, s2, s3;
  logic [0:7]       d1, d2;
  logic [1:0]       fill;
  logic             armed;
  logic             accept;
  logic [IDX_W-1:0] count, count_nxt;
  logic [TO_W-1:0]  to_cnt, to_nxt;
  logic             dv_nxt, fd_nxt, fe_nxt, led1_nxt, led2_nxt;
  logic [IDX_W-1:0] idx_nxt;

  // fill marks when s2 holds a real sample, so a strobe that is already high
  // at reset release is never mistaken for a fresh rise.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      d1    <= '0;
      d2    <= '0;
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      s1   <= rpi_strobe;
      s2   <= s1;
      s3   <= s2;
      d1   <= RPI_IO;
      d2   <= d1;
      fill <= {fill[0], 1'b1};
      if (fill[1] && !s2)
        armed <= 1'b1;
    end
  end

  assign accept = s2 & ~s3 & armed;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    to_nxt    = to_cnt;
    idx_nxt   = byte_idx;
    dv_nxt    = 1'b0;
    fd_nxt    = 1'b0;
    fe_nxt    = 1'b0;
    led1_nxt  = LED1;
    led2_nxt  = LED2;
    case (state)
      IDLE: begin
        to_nxt = '0;
        if (accept) begin
          dv_nxt  = 1'b1;
          idx_nxt = '0;
          if (FRAME_BYTES == 1) begin
            fd_nxt    = 1'b1;
            led1_nxt  = ~LED1;
            count_nxt = '0;
          end else begin
            count_nxt = IDX_W'(1);
            state_nxt = RECV;
          end
        end
      end
      RECV: begin
        // A rise on the terminal cycle still wins over the abort.
        if (accept) begin
          dv_nxt  = 1'b1;
          idx_nxt = count;
          to_nxt  = '0;
          if (count == IDX_LAST) begin
            fd_nxt    = 1'b1;
            led1_nxt  = ~LED1;
            count_nxt = '0;
            state_nxt = IDLE;
          end else begin
            count_nxt = count + IDX_W'(1);
          end
        end else if (to_cnt == TO_LAST) begin
          fe_nxt    = 1'b1;
          led2_nxt  = 1'b1;
          count_nxt = '0;
          to_nxt    = '0;
          state_nxt = IDLE;
        end else begin
          to_nxt = to_cnt + TO_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      to_cnt     <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      byte_idx   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      LED1       <= 1'b0;
      LED2       <= 1'b0;
      rpi_ack    <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      to_cnt     <= to_nxt;
      data_valid <= dv_nxt;
      byte_idx   <= idx_nxt;
      frame_done <= fd_nxt;
      frame_err  <= fe_nxt;
      busy       <= (state_nxt == RECV);
      LED1       <= led1_nxt;
      LED2       <= led2_nxt;
      if (accept)
        data_out <= d2;
      if (accept)
        rpi_ack <= 1'b1;
      else if (!s2)
        rpi_ack <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rpi_bus_rx.sv
// Directed bench for rpi_bus_rx: handshakes, latency, timeout abort, terminal-cycle
// rise, reset with strobe held high, and back-to-back frames from a vector table.
module tb_rpi_bus_rx;

  logic       clk_100mhz = 1'b0;
  logic       rst_n      = 1'b0;
  logic [0:7] rpi_io     = '0;
  logic       rpi_strobe = 1'b0;
  logic       rpi_ack;
  logic [0:7] data_out;
  logic       data_valid;
  logic [0:0] byte_idx;
  logic       frame_done, frame_err, busy, LED1, LED2;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       idx;
    logic       fd;
    logic       led1;
  } vec_t;

  vec_t vec [8];

  rpi_bus_rx #(.FRAME_BYTES(2), .IDX_W(1), .TIMEOUT_CYC(100)) dut (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .RPI_IO     (rpi_io),
    .rpi_strobe (rpi_strobe),
    .rpi_ack    (rpi_ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .byte_idx   (byte_idx),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy),
    .LED1       (LED1),
    .LED2       (LED2)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  always @(posedge clk_100mhz) cyc <= cyc + 1;

  always @(negedge clk_100mhz) begin
    if (data_valid) dv_cnt <= dv_cnt + 1;
    if (frame_err)  fe_cnt <= fe_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Full 4-phase handshake; reports what was seen on the data_valid cycle.
  task automatic hs(input logic [7:0] b, output logic [7:0] d, output logic idx,
                    output logic fd, output int t, output logic ok);
    rpi_io = b;
    repeat (2) @(negedge clk_100mhz);
    rpi_strobe = 1'b1;
    ok = 1'b0; d = '0; idx = 1'b0; fd = 1'b0; t = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_100mhz);
      if (data_valid) begin
        ok = 1'b1; d = data_out; idx = byte_idx[0]; fd = frame_done; t = cyc;
        break;
      end
    end
    rpi_strobe = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_100mhz);
      if (!rpi_ack) break;
    end
    repeat (2) @(negedge clk_100mhz);
  endtask

  logic [7:0] d;
  logic       idx, fd, ok;
  int         t_dv, t_fe, n0, f0;

  initial begin
    vec[0] = '{8'h81, 1'b0, 1'b0, 1'b0};
    vec[1] = '{8'h42, 1'b1, 1'b1, 1'b1};
    vec[2] = '{8'hFF, 1'b0, 1'b0, 1'b1};
    vec[3] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vec[4] = '{8'h5A, 1'b0, 1'b0, 1'b0};
    vec[5] = '{8'hC3, 1'b1, 1'b1, 1'b1};
    vec[6] = '{8'h01, 1'b0, 1'b0, 1'b1};
    vec[7] = '{8'h80, 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk_100mhz);
    chk("rst_outputs", {rpi_ack, data_valid, byte_idx, frame_done, frame_err, busy, LED1, LED2}, 0);
    chk("rst_data", data_out, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_100mhz);

    // Two-byte frame
    hs(8'hA5, d, idx, fd, t_dv, ok);
    chk("b0_seen", ok, 1);
    chk("b0_data", d, 8'hA5);
    chk("b0_idx", idx, 0);
    chk("b0_fd", fd, 0);
    chk("b0_busy", busy, 1);
    hs(8'h3C, d, idx, fd, t_dv, ok);
    chk("b1_seen", ok, 1);
    chk("b1_data", d, 8'h3C);
    chk("b1_idx", idx, 1);
    chk("b1_fd", fd, 1);
    chk("b1_led1", LED1, 1);
    chk("b1_busy", busy, 0);

    // Latency, long strobe, ack release, then timeout abort
    rpi_io = 8'h5A;
    repeat (2) @(negedge clk_100mhz);
    n0 = dv_cnt;
    rpi_strobe = 1'b1;
    @(negedge clk_100mhz);
    chk("lat_k0_dv", data_valid, 0);
    @(negedge clk_100mhz);
    chk("lat_k1_dv_ack", {data_valid, rpi_ack}, 0);
    @(negedge clk_100mhz);
    chk("lat_k2_dv_ack", {data_valid, rpi_ack}, 2'b11);
    chk("lat_data", data_out, 8'h5A);
    t_dv = cyc;
    @(negedge clk_100mhz);
    chk("lat_k3_dv", data_valid, 0);
    repeat (46) @(negedge clk_100mhz);
    rpi_strobe = 1'b0;
    chk("long_strobe_one_dv", dv_cnt - n0, 1);
    @(negedge clk_100mhz);
    chk("ack_m0", rpi_ack, 1);
    @(negedge clk_100mhz);
    chk("ack_m1", rpi_ack, 1);
    @(negedge clk_100mhz);
    chk("ack_m2", rpi_ack, 0);
    t_fe = -1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk_100mhz);
      if (frame_err) begin t_fe = cyc; break; end
    end
    chk("to_delay", t_fe - t_dv, 100);
    chk("to_led2", LED2, 1);
    chk("to_busy", busy, 0);
    chk("to_no_dv", dv_cnt - n0, 1);
    @(negedge clk_100mhz);
    chk("to_pulse", frame_err, 0);

    // Next byte starts at idx 0; second byte's rise lands on the terminal cycle
    f0 = fe_cnt;
    hs(8'h11, d, idx, fd, t_dv, ok);
    chk("after_to_idx", {ok, idx}, 2'b10);
    rpi_io = 8'h22;
    while (cyc < t_dv + 97) @(negedge clk_100mhz);
    rpi_strobe = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_100mhz);
      if (data_valid) begin ok = 1'b1; t_fe = cyc; d = data_out; idx = byte_idx[0]; fd = frame_done; break; end
    end
    chk("term_seen", ok, 1);
    chk("term_delay", t_fe - t_dv, 100);
    chk("term_data_idx_fd", {d, idx, fd}, {8'h22, 1'b1, 1'b1});
    chk("term_led1", LED1, 0);
    repeat (3) @(negedge clk_100mhz);
    rpi_strobe = 1'b0;
    repeat (110) @(negedge clk_100mhz);
    chk("term_no_err", fe_cnt - f0, 0);
    chk("term_busy", busy, 0);

    // Reset mid-frame with strobe high
    hs(8'h77, d, idx, fd, t_dv, ok);
    chk("mid_busy", busy, 1);
    rpi_io = 8'h66;
    repeat (2) @(negedge clk_100mhz);
    rpi_strobe = 1'b1;
    repeat (5) @(negedge clk_100mhz);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {rpi_ack, data_valid, byte_idx, frame_done, frame_err, busy, LED1, LED2}, 0);
    chk("mid_rst_data", data_out, 0);
    repeat (3) @(negedge clk_100mhz);
    rst_n = 1'b1;
    n0 = dv_cnt;
    repeat (20) @(negedge clk_100mhz);
    chk("held_strobe_no_dv", {dv_cnt - n0, 31'(rpi_ack)}, 0);
    rpi_strobe = 1'b0;
    repeat (5) @(negedge clk_100mhz);
    hs(8'h99, d, idx, fd, t_dv, ok);
    chk("post_rst_byte", {ok, d, idx}, {1'b1, 8'h99, 1'b0});

    // Back-to-back frames at minimum phases
    rst_n = 1'b0;
    rpi_io = vec[0].data;
    repeat (2) @(negedge clk_100mhz);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_100mhz);
    n0 = dv_cnt;
    for (int i = 0; i < 8; i++) begin
      rpi_strobe = 1'b1;
      repeat (3) @(negedge clk_100mhz);
      chk($sformatf("vec%0d_dv_ack", i), {data_valid, rpi_ack}, 2'b11);
      chk($sformatf("vec%0d_data", i), data_out, vec[i].data);
      chk($sformatf("vec%0d_idx_fd_led1", i), {byte_idx, frame_done, LED1},
          {vec[i].idx, vec[i].fd, vec[i].led1});
      rpi_strobe = 1'b0;
      if (i < 7) rpi_io = vec[i + 1].data;
      repeat (3) @(negedge clk_100mhz);
      chk($sformatf("vec%0d_ack_low", i), rpi_ack, 0);
    end
    chk("b2b_dv_count", dv_cnt - n0, 8);
    chk("b2b_end", {LED1, LED2, busy}, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
